// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising local-field accumulator.
package ising_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam int unsigned LANES         = 4;
  localparam int unsigned W_WIDTH_DEF   = 8;
  localparam int unsigned ACC_WIDTH_DEF = 24;

endpackage

// File: rtl/ising_lane_mac.sv
// Combinational signed sum of four +/-w products for one coupling word and spin nibble.
module ising_lane_mac
  import ising_pkg::*;
#(
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic [LANES*W_WIDTH-1:0] word,
  input  logic [LANES-1:0]         spins,
  output logic [ACC_WIDTH-1:0]     sum
);

  logic [ACC_WIDTH-1:0] w_ext;

  always_comb begin
    sum   = '0;
    w_ext = '0;
    for (int k = 0; k < LANES; k++) begin
      // Extend before negating so that -(-2^(W-1)) is representable.
      w_ext = {{(ACC_WIDTH-W_WIDTH){word[k*W_WIDTH+W_WIDTH-1]}}, word[k*W_WIDTH +: W_WIDTH]};
      sum   = spins[k] ? (sum + w_ext) : (sum - w_ext);
    end
  end

endmodule

// File: rtl/ising_field_accum.sv
// Streams coupling rows four weights per word and emits one local field per row.
module ising_field_accum
  import ising_pkg::*;
#(
  parameter int unsigned N_SPINS   = 64,
  parameter int unsigned W_WIDTH   = W_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  input  logic                 spin_load,
  input  logic [N_SPINS-1:0]   spin_in,
  input  logic                 word_valid,
  input  logic [31:0]          word_data,
  output logic                 word_ready,
  output logic                 field_valid,
  input  logic                 field_ready,
  output logic [ACC_WIDTH-1:0] field_data,
  output logic [7:0]           field_row,
  output logic                 busy,
  output logic                 sweep_done
);

  localparam int unsigned CW = $clog2(N_SPINS);
  localparam logic [CW-1:0] LAST_COL = CW'(N_SPINS - LANES);
  localparam logic [7:0]    LAST_ROW = 8'(N_SPINS - 1);

  state_e               state_q, state_d;
  logic [7:0]           row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [N_SPINS-1:0]   spins_q, spins_d;
  logic                 done_q, done_d;
  logic [ACC_WIDTH-1:0] lane_sum;

  ising_lane_mac #(
    .W_WIDTH  (W_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .word (word_data),
    .spins(spins_q[col_q +: LANES]),
    .sum  (lane_sum)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    spins_d = spins_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (spin_load) spins_d = spin_in;
        if (start) begin
          state_d = StAccum;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
        end
      end
      StAccum: begin
        if (word_valid) begin
          acc_d = acc_q + lane_sum;
          col_d = col_q + CW'(LANES);
          if (col_q == LAST_COL) state_d = StHold;
        end
      end
      StHold: begin
        if (field_ready) begin
          acc_d = '0;
          col_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = StIdle;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = StAccum;
            row_d   = row_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      spins_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      spins_q <= spins_d;
      done_q  <= done_d;
    end
  end

  assign word_ready  = (state_q == StAccum);
  assign field_valid = (state_q == StHold);
  assign field_data  = acc_q;
  assign field_row   = row_q;
  assign busy        = (state_q != StIdle);
  assign sweep_done  = done_q;

endmodule

// File: tb/tb_ising_field_accum.sv
// Scoreboard bench: the driver queues expected row fields, a monitor checks each handshake.
module tb_ising_field_accum;

  localparam int N = 64;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic        spin_load;
  logic [N-1:0] spin_in;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        field_valid;
  logic        field_ready;
  logic [23:0] field_data;
  logic [7:0]  field_row;
  logic        busy;
  logic        sweep_done;

  ising_field_accum #(
    .N_SPINS  (N),
    .W_WIDTH  (8),
    .ACC_WIDTH(24)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .start      (start),
    .spin_load  (spin_load),
    .spin_in    (spin_in),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .field_valid(field_valid),
    .field_ready(field_ready),
    .field_data (field_data),
    .field_row  (field_row),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          row;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  bit   done_expect = 0;
  int   ready_mode = 0;  // 0 always ready, 1 random, 2 one long stall
  int   stall_row = 2;
  bit   stalled = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] weight_of(input int mode, input int r, input int c);
    logic [31:0] h;
    if (mode == 0) return 8'h01;
    if (mode == 1) return 8'h80;
    h = 32'((r * 131 + c * 29 + mode * 71) ^ (r * c));
    return h[7:0];
  endfunction

  function automatic logic [31:0] make_word(input int mode, input int r, input int c);
    return {weight_of(mode, r, c + 3), weight_of(mode, r, c + 2),
            weight_of(mode, r, c + 1), weight_of(mode, r, c)};
  endfunction

  // Reference: plain integer sum of +/-w with w interpreted as two's complement.
  function automatic logic [23:0] model_row(input int mode, input logic [N-1:0] sp, input int r);
    int s = 0;
    int w;
    logic [7:0] wb;
    for (int c = 0; c < N; c++) begin
      wb = weight_of(mode, r, c);
      w  = (wb >= 8'd128) ? int'(wb) - 256 : int'(wb);
      s  = sp[c] ? s + w : s - w;
    end
    return 24'(s);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_field_valid"}, field_valid, 0);
    chk({tag, "_field_data"}, field_data, 0);
    chk({tag, "_field_row"}, field_row, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sweep_done"}, sweep_done, 0);
  endtask

  task automatic run_sweep(input int mode, input logic [N-1:0] spins, input bit load,
                           input bit early, input bit gaps, input int load_row,
                           input logic [N-1:0] load_vec, input int abort_row,
                           input bit use_hand, input int hand);
    exp_t e;
    if (early) begin
      @(posedge ACLK); #1;
      spin_in = spins; spin_load = 1'b1;
      @(posedge ACLK); #1;
      spin_load = 1'b0;
    end
    @(posedge ACLK); #1;
    spin_in = spins; spin_load = load; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0; spin_load = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int r = 0; r < N; r++) begin
      e.row = r;
      e.val = use_hand ? 24'(hand) : model_row(mode, spins, r);
      sb.push_back(e);
      for (int c = 0; c < N; c += 4) begin
        int  waited = 0;
        bit  taken = 0;
        if (r == load_row && c == 0) begin
          spin_in = load_vec; spin_load = 1'b1;
        end
        while (!taken) begin
          word_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          word_data  = make_word(mode, r, c);
          @(negedge ACLK);
          if (word_valid && word_ready) taken = 1;
          @(posedge ACLK); #1;
          spin_load = 1'b0;
          waited++;
          if (!taken && waited > 200) begin
            chk("word_accept_timeout", 0, 1);
            word_valid = 1'b0;
            return;
          end
        end
        if (r == abort_row && c == 24) begin
          ARESET = 1'b1; word_valid = 1'b0;
          #1;
          check_all_zero("mid_reset");
          sb.delete();
          done_expect = 0;
          @(negedge ACLK);
          ARESET = 1'b0;
          return;
        end
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_end(input int target);
    int n = 0;
    word_valid = 1'b0;
    while ((sb.size() != 0 || done_count < target) && n < 400) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("sweep_done_count", done_count, target);
    @(negedge ACLK);
    chk("busy_idle_after_sweep", busy, 0);
  endtask

  // Monitor: pops expected row results on every field handshake.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (sweep_done || done_expect) chk("sweep_done_pulse", sweep_done, done_expect);
      if (sweep_done) done_count++;
      done_expect = 0;
      if (field_valid && field_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("field_row", field_row, 8'(e.row));
          chk("field_data", field_data, e.val);
          if (e.row == N - 1) done_expect = 1;
        end
      end
    end
  end

  // Downstream ready generator, including a held-off HOLD with stability checks.
  initial begin
    logic [23:0] held;
    field_ready = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      if (ready_mode == 1) begin
        field_ready = ($urandom_range(0, 3) != 0);
      end else if (ready_mode == 2 && !stalled && field_valid && field_row == 8'(stall_row)) begin
        field_ready = 1'b0;
        held = field_data;
        for (int i = 0; i < 10; i++) begin
          @(negedge ACLK);
          chk("stall_field_valid", field_valid, 1);
          chk("stall_field_data_stable", field_data, held);
          chk("stall_word_ready_low", word_ready, 0);
          chk("stall_word_valid_offered", word_valid, 1);
          @(posedge ACLK); #1;
        end
        stalled = 1;
        field_ready = 1'b1;
      end else begin
        field_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] alt;
    logic [N-1:0] rnd;
    int sweeps = 0;
    ARESET = 1'b1; start = 1'b0; spin_load = 1'b0; spin_in = '0;
    word_valid = 1'b0; word_data = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    // All spins +1, all weights +1; spin load shares the start cycle.
    ready_mode = 0;
    run_sweep(0, '1, 1, 0, 0, -1, '0, -1, 1, 64);
    wait_end(++sweeps);

    // Alternating spins, weights -128: every field cancels; row 2 held off 10 cycles.
    alt = {(N/2){2'b10}};
    ready_mode = 2; stall_row = 2; stalled = 0;
    run_sweep(1, alt, 1, 0, 0, -1, '0, -1, 1, 0);
    wait_end(++sweeps);
    chk("stall_happened", stalled, 1);

    // Spin 1 flipped to -1 gives +256; a load attempted mid-sweep must be ignored.
    ready_mode = 0;
    run_sweep(1, alt & ~64'h2, 1, 0, 0, 5, alt | 64'h1, -1, 1, 256);
    wait_end(++sweeps);

    // Spin 0 flipped to +1 gives -256, loaded in IDLE ahead of start.
    run_sweep(1, alt | 64'h1, 0, 1, 0, -1, '0, -1, 1, -256);
    wait_end(++sweeps);

    // Reset after 7 words of row 3; spins return to all -1.
    rnd = {$urandom(), $urandom()};
    run_sweep(2, rnd, 1, 0, 0, -1, '0, 3, 0, 0);
    chk("no_done_after_abort", done_count, sweeps);
    run_sweep(2, '0, 0, 0, 0, -1, '0, -1, 0, 0);
    wait_end(++sweeps);

    // Random word gaps and result stalls over three sweeps.
    ready_mode = 1;
    for (int s = 0; s < 3; s++) begin
      rnd = {$urandom(), $urandom()};
      run_sweep(3 + s, rnd, 1, 0, 1, -1, '0, -1, 0, 0);
      wait_end(++sweeps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
